// File: rtl/delay_ctrl_pkg.sv
// Shared constants and types for the delay controller.
// Holds register offsets, STATUS/CTRL bit positions and datapath widths.
package delay_ctrl_pkg;

   localparam int unsigned DELAY_W  = 4;
   localparam int unsigned ADDR_W   = 2;
   localparam int unsigned DATA_W   = 32;
   localparam int unsigned EVCNT_W  = 16;

   // Avalon-MM word offsets
   typedef enum logic [ADDR_W-1:0] {
      REG_DELAY   = 2'd0,
      REG_STATUS  = 2'd1,
      REG_EVCOUNT = 2'd2,
      REG_CTRL    = 2'd3
   } reg_addr_e;

   localparam int unsigned STATUS_AT_MIN_BIT = 0;
   localparam int unsigned STATUS_AT_MAX_BIT = 1;
   localparam int unsigned STATUS_LOCK_BIT   = 2;

   localparam int unsigned CTRL_LOCK_BIT = 0;
   localparam int unsigned CTRL_CLR_BIT  = 1;

   // STATUS payload, LSB first: at_min(0), at_max(1), lock(2)
   typedef struct packed {
      logic lock;
      logic at_max;
      logic at_min;
   } status_t;

endpackage

// File: rtl/delay_ctrl_if.sv
// Avalon-MM slave bus bundle for the delay controller.
// master drives address/strobes/writedata; slave returns readdata.
interface delay_ctrl_if;
   import delay_ctrl_pkg::*;

   logic [ADDR_W-1:0] avs_address;
   logic              avs_read;
   logic              avs_write;
   logic [DATA_W-1:0] avs_writedata;
   logic [DATA_W-1:0] avs_readdata;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata
   );

endinterface

// File: rtl/delay_ctrl_sat_updown.sv
// Saturating up/down counter with clamped parallel load.
// Ports: clk, reset_n (sync, active-low), load/load_val (priority load,
// clamped to [MIN,MAX]), inc/dec (both high = hold), value (registered),
// blocked_c (combinational: a single-direction step hit a bound this cycle).
module sat_updown #(
   parameter int unsigned W   = 4,
   parameter int unsigned MIN = 0,
   parameter int unsigned MAX = 15,
   parameter int unsigned RST = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] value,
   output logic         blocked_c
);

   localparam logic [W-1:0] MIN_V = W'(MIN);
   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] RST_V = W'(RST);

   logic         up_c;
   logic         dn_c;
   logic [W-1:0] clamp_c;

   // Step qualification and load clamp; the +1 form avoids an always-false
   // unsigned compare when MIN is zero.
   always_comb begin
      up_c      = !load && inc && !dec;
      dn_c      = !load && dec && !inc;
      blocked_c = (up_c && (value == MAX_V)) || (dn_c && (value == MIN_V));
      clamp_c   = load_val;
      if ((32'(load_val) + 32'd1) <= 32'(MIN))
         clamp_c = MIN_V;
      else if (32'(load_val) > 32'(MAX))
         clamp_c = MAX_V;
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         value <= RST_V;
      else if (load)
         value <= clamp_c;
      else if (up_c && (value != MAX_V))
         value <= value + W'(1);
      else if (dn_c && (value != MIN_V))
         value <= value - W'(1);
   end

endmodule

// File: rtl/delay_ctrl.sv
// Delay register with key pulses, saturation event counter and Avalon-MM access.
// Ports: clk, reset_n (sync, active-low), bus (Avalon-MM slave modport),
// coe_slower/coe_faster (single-cycle key pulses), coe_delay (registered delay).
module delay_ctrl
   import delay_ctrl_pkg::*;
#(
   parameter int unsigned DELAY_RESET = 8,
   parameter int unsigned DELAY_MIN   = 0,
   parameter int unsigned DELAY_MAX   = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   delay_ctrl_if.slave        bus,
   input  logic               coe_slower,
   input  logic               coe_faster,
   output logic [DELAY_W-1:0] coe_delay
);

   logic               lock_q;
   logic [EVCNT_W-1:0] evcount_q;
   logic               wr_delay_c;
   logic               wr_ctrl_c;
   logic               clr_c;
   logic               key_en_c;
   logic               blocked_c;
   status_t            status_c;
   logic [DATA_W-1:0]  rd_c;
   logic               unused_wdata;

   assign unused_wdata = ^bus.avs_writedata[DATA_W-1:DELAY_W];

   // Write decode; a DELAY write or LOCK suppresses key pulses entirely
   always_comb begin
      wr_delay_c = bus.avs_write && (reg_addr_e'(bus.avs_address) == REG_DELAY);
      wr_ctrl_c  = bus.avs_write && (reg_addr_e'(bus.avs_address) == REG_CTRL);
      clr_c      = wr_ctrl_c && bus.avs_writedata[CTRL_CLR_BIT];
      key_en_c   = !lock_q && !wr_delay_c;
   end

   sat_updown #(
      .W   (DELAY_W),
      .MIN (DELAY_MIN),
      .MAX (DELAY_MAX),
      .RST (DELAY_RESET)
   ) u_delay (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (wr_delay_c),
      .load_val  (bus.avs_writedata[DELAY_W-1:0]),
      .inc       (key_en_c && coe_slower),
      .dec       (key_en_c && coe_faster),
      .value     (coe_delay),
      .blocked_c (blocked_c)
   );

   // LOCK bit and saturating event counter; clear beats a same-cycle event
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         lock_q    <= 1'b0;
         evcount_q <= '0;
      end else begin
         if (wr_ctrl_c)
            lock_q <= bus.avs_writedata[CTRL_LOCK_BIT];
         if (clr_c)
            evcount_q <= '0;
         else if (blocked_c && (evcount_q != '1))
            evcount_q <= evcount_q + EVCNT_W'(1);
      end
   end

   // Read mux over pre-write state
   always_comb begin
      status_c.at_min = (coe_delay == DELAY_W'(DELAY_MIN));
      status_c.at_max = (coe_delay == DELAY_W'(DELAY_MAX));
      status_c.lock   = lock_q;
      rd_c            = '0;
      case (reg_addr_e'(bus.avs_address))
         REG_DELAY:   rd_c = DATA_W'(coe_delay);
         REG_STATUS:  rd_c = DATA_W'(status_c);
         REG_EVCOUNT: rd_c = DATA_W'(evcount_q);
         REG_CTRL:    rd_c = DATA_W'(lock_q);
         default:     rd_c = '0;
      endcase
   end

   // Read data holds between reads
   always_ff @(posedge clk) begin
      if (!reset_n)
         bus.avs_readdata <= '0;
      else if (bus.avs_read)
         bus.avs_readdata <= rd_c;
   end

endmodule

// File: tb/tb_delay_ctrl.sv
// Self-checking bench for delay_ctrl: directed scenarios plus randomized
// traffic checked against an integer-level reference model.
module tb_delay_ctrl;

   localparam int D_RST = 8;
   localparam int D_MIN = 0;
   localparam int D_MAX = 15;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       coe_slower;
   logic       coe_faster;
   logic [3:0] coe_delay;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int          m_delay = D_RST;
   int          m_ev    = 0;
   bit          m_lock  = 1'b0;
   logic [31:0] m_rd    = 32'd0;

   delay_ctrl_if bus ();

   delay_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .coe_slower (coe_slower),
      .coe_faster (coe_faster),
      .coe_delay  (coe_delay)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] m_reg(input logic [1:0] a);
      logic [31:0] r;
      r = 32'd0;
      case (a)
         2'd0: r = 32'(m_delay);
         2'd1: begin
            r[0] = (m_delay == D_MIN);
            r[1] = (m_delay == D_MAX);
            r[2] = m_lock;
         end
         2'd2: r = 32'(m_ev);
         default: r[0] = m_lock;
      endcase
      return r;
   endfunction

   // One clock: compute model next state from current inputs, then advance
   task automatic cycle();
      int          nd = m_delay;
      int          ne = m_ev;
      bit          nl = m_lock;
      logic [31:0] nr = m_rd;
      bit          clr = 1'b0;
      bit          blk = 1'b0;
      bit          wr_d;
      int          t;
      if (!reset_n) begin
         nd = D_RST; ne = 0; nl = 1'b0; nr = 32'd0;
      end else begin
         if (bus.avs_read) nr = m_reg(bus.avs_address);
         wr_d = bus.avs_write && (bus.avs_address == 2'd0);
         if (wr_d) begin
            t = int'(bus.avs_writedata[3:0]);
            if (t < D_MIN) t = D_MIN;
            if (t > D_MAX) t = D_MAX;
            nd = t;
         end
         if (bus.avs_write && bus.avs_address == 2'd3) begin
            nl  = bus.avs_writedata[0];
            clr = bus.avs_writedata[1];
         end
         if (!wr_d && !m_lock && (coe_slower != coe_faster)) begin
            t = coe_slower ? m_delay + 1 : m_delay - 1;
            if (t > D_MAX || t < D_MIN) blk = 1'b1;
            else nd = t;
         end
         if (clr) ne = 0;
         else if (blk && ne < 65535) ne = ne + 1;
      end
      @(posedge clk);
      #1;
      m_delay = nd; m_ev = ne; m_lock = nl; m_rd = nr;
   endtask

   task automatic idle_inputs();
      bus.avs_address = 2'd0; bus.avs_read = 1'b0; bus.avs_write = 1'b0;
      bus.avs_writedata = 32'd0; coe_slower = 1'b0; coe_faster = 1'b0;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d,
                            input bit sl = 1'b0, input bit fa = 1'b0);
      bus.avs_address = a; bus.avs_write = 1'b1; bus.avs_writedata = d;
      coe_slower = sl; coe_faster = fa;
      cycle();
      idle_inputs();
   endtask

   task automatic bus_read(input logic [1:0] a);
      bus.avs_address = a; bus.avs_read = 1'b1;
      cycle();
      idle_inputs();
   endtask

   task automatic pulse(input bit sl, input bit fa);
      coe_slower = sl; coe_faster = fa;
      cycle();
      idle_inputs();
      cycle();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cycle(); cycle();
      reset_n = 1'b1;
      n_cmp++;
      if (coe_delay !== 4'd8) begin n_bad++; $display("FAIL reset_coe_delay got=%0h exp=8", coe_delay); end
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata got=%0h exp=0", bus.avs_readdata); end
      bus_read(2'd0);
      n_cmp++;
      if (bus.avs_readdata !== 32'd8) begin n_bad++; $display("FAIL reset_rd_delay got=%0h exp=8", bus.avs_readdata); end
      bus_read(2'd1);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL reset_rd_status got=%0h exp=0", bus.avs_readdata); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL reset_rd_evcount got=%0h exp=0", bus.avs_readdata); end
   endtask

   task automatic test_saturate_up();
      for (int i = 0; i < 7; i++) begin
         pulse(1'b1, 1'b0);
         n_cmp++;
         if (coe_delay !== 4'(9 + i)) begin n_bad++; $display("FAIL up_step%0d got=%0d exp=%0d", i, coe_delay, 9 + i); end
      end
      bus_read(2'd1);
      n_cmp++;
      if (bus.avs_readdata !== 32'h2) begin n_bad++; $display("FAIL up_status got=%0h exp=2", bus.avs_readdata); end
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
      n_cmp++;
      if (coe_delay !== 4'd15) begin n_bad++; $display("FAIL up_sat got=%0d exp=15", coe_delay); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd3) begin n_bad++; $display("FAIL up_evcount got=%0d exp=3", bus.avs_readdata); end
   endtask

   task automatic test_write_delay();
      bus_write(2'd0, 32'h2A);
      n_cmp++;
      if (coe_delay !== 4'hA) begin n_bad++; $display("FAIL wr_delay_2a got=%0h exp=a", coe_delay); end
      bus_write(2'd0, 32'h3, 1'b0, 1'b1);
      n_cmp++;
      if (coe_delay !== 4'd3) begin n_bad++; $display("FAIL wr_vs_pulse got=%0d exp=3", coe_delay); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd3) begin n_bad++; $display("FAIL wr_vs_pulse_ev got=%0d exp=3", bus.avs_readdata); end
   endtask

   task automatic test_both_and_lock();
      bus_write(2'd0, 32'd5);
      pulse(1'b1, 1'b1);
      n_cmp++;
      if (coe_delay !== 4'd5) begin n_bad++; $display("FAIL both_high got=%0d exp=5", coe_delay); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd3) begin n_bad++; $display("FAIL both_high_ev got=%0d exp=3", bus.avs_readdata); end
      bus_write(2'd3, 32'h1);
      for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1);
      n_cmp++;
      if (coe_delay !== 4'd5) begin n_bad++; $display("FAIL lock_hold got=%0d exp=5", coe_delay); end
      bus_read(2'd1);
      n_cmp++;
      if (bus.avs_readdata !== 32'h4) begin n_bad++; $display("FAIL lock_status got=%0h exp=4", bus.avs_readdata); end
      bus_read(2'd3);
      n_cmp++;
      if (bus.avs_readdata !== 32'h1) begin n_bad++; $display("FAIL lock_ctrl got=%0h exp=1", bus.avs_readdata); end
      bus_write(2'd3, 32'h0);
   endtask

   task automatic test_clear();
      bus_write(2'd3, 32'h2);
      bus_write(2'd0, 32'd0);
      pulse(1'b0, 1'b1);
      pulse(1'b0, 1'b1);
      n_cmp++;
      if (coe_delay !== 4'd0) begin n_bad++; $display("FAIL min_hold got=%0d exp=0", coe_delay); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd2) begin n_bad++; $display("FAIL min_ev got=%0d exp=2", bus.avs_readdata); end
      bus_write(2'd3, 32'h2);
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL clr_ev got=%0d exp=0", bus.avs_readdata); end
      bus_read(2'd3);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL clr_ctrl got=%0h exp=0", bus.avs_readdata); end
      // clear coinciding with a blocked decrement: clear wins
      pulse(1'b0, 1'b1);
      bus_write(2'd3, 32'h2, 1'b0, 1'b1);
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL clr_vs_event got=%0d exp=0", bus.avs_readdata); end
      // read-only registers ignore writes
      bus_write(2'd2, 32'h1234);
      bus_write(2'd1, 32'hFFFF_FFFF);
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL ro_evcount got=%0h exp=0", bus.avs_readdata); end
      bus_read(2'd1);
      n_cmp++;
      if (bus.avs_readdata !== 32'h1) begin n_bad++; $display("FAIL ro_status got=%0h exp=1", bus.avs_readdata); end
   endtask

   task automatic test_read_timing();
      // same-cycle read and write of DELAY returns the old value
      bus.avs_address = 2'd0; bus.avs_read = 1'b1; bus.avs_write = 1'b1;
      bus.avs_writedata = 32'd7;
      cycle();
      idle_inputs();
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL rd_before_wr got=%0d exp=0", bus.avs_readdata); end
      n_cmp++;
      if (coe_delay !== 4'd7) begin n_bad++; $display("FAIL rd_wr_delay got=%0d exp=7", coe_delay); end
      cycle(); cycle();
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL rd_hold got=%0d exp=0", bus.avs_readdata); end
      bus_read(2'd0);
      n_cmp++;
      if (bus.avs_readdata !== 32'd7) begin n_bad++; $display("FAIL rd_new got=%0d exp=7", bus.avs_readdata); end
   endtask

   task automatic test_reset_mid();
      bus_write(2'd0, 32'd12);
      pulse(1'b0, 1'b0);
      bus_read(2'd0);
      bus_write(2'd3, 32'h1);
      reset_n = 1'b0; coe_slower = 1'b1;
      bus.avs_address = 2'd0; bus.avs_write = 1'b1; bus.avs_writedata = 32'd3;
      cycle();
      idle_inputs();
      reset_n = 1'b1;
      n_cmp++;
      if (coe_delay !== 4'd8) begin n_bad++; $display("FAIL mid_reset_delay got=%0d exp=8", coe_delay); end
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_rd got=%0h exp=0", bus.avs_readdata); end
      bus_read(2'd2);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_ev got=%0d exp=0", bus.avs_readdata); end
      bus_read(2'd3);
      n_cmp++;
      if (bus.avs_readdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_lock got=%0h exp=0", bus.avs_readdata); end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 600; i++) begin
         reset_n           = ($urandom_range(0, 99) != 0);
         bus.avs_address   = 2'($urandom_range(0, 3));
         bus.avs_read      = ($urandom_range(0, 2) == 0);
         r                 = $urandom_range(0, 9);
         bus.avs_write     = (r == 0);
         bus.avs_writedata = $urandom;
         if (bus.avs_address == 2'd3 && $urandom_range(0, 3) != 0)
            bus.avs_writedata[1] = 1'b0;
         if (bus.avs_address == 2'd3 && $urandom_range(0, 1) != 0)
            bus.avs_writedata[0] = 1'b0;
         r          = $urandom_range(0, 7);
         coe_slower = (r == 1 || r == 2 || r == 3 || r == 7);
         coe_faster = (r == 4 || r == 5 || r == 7);
         cycle();
         n_cmp++;
         if (coe_delay !== 4'(m_delay)) begin n_bad++; $display("FAIL rand_delay@%0d got=%0d exp=%0d", i, coe_delay, m_delay); end
         n_cmp++;
         if (bus.avs_readdata !== m_rd) begin n_bad++; $display("FAIL rand_rd@%0d got=%0h exp=%0h", i, bus.avs_readdata, m_rd); end
      end
      idle_inputs();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      idle_inputs();
      #1;
      test_reset();
      test_saturate_up();
      test_write_delay();
      test_both_and_lock();
      test_clear();
      test_read_timing();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
